// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial adder.
//   WIDTH_DEFAULT : default operand/sum width in bits (legal range 2..32)
//   state_t       : control FSM encoding (IDLE, RUN, DONE)
package serial_arith_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle of the bit-serial adder.
//   start       : request to begin an addition (acted on only while idle)
//   a, b, cin   : operands and carry-in, captured when start is accepted
//   busy        : addition in progress
//   done        : one-cycle pulse, sum/cout hold the new result
//   sum, cout   : registered result and carry-out of the last addition
// master drives the request side, slave (the adder) drives the result side.
interface serial_adder_if
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/full_adder.sv
// One-bit full-adder cell.
//   x, y : addend bits
//   z    : carry-in
//   S    : sum bit
//   C    : carry-out
module full_adder (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic S,
  output logic C
);

  logic xy_half;

  assign xy_half = x ^ y;
  assign S       = xy_half ^ z;
  assign C       = (x & y) | (z & xy_half);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: {cout,sum} = a + b + cin, one bit per clock,
// LSB first, through a single full-adder cell.
//   clk : sole clock, all state changes on the rising edge
//   rst : synchronous active-high reset, takes priority over start
//   bus : serial_adder_if slave port (start/a/b/cin in, busy/done/sum/cout out)
// A start accepted at edge t yields done in the cycle after edge t+WIDTH.
module serial_adder
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);

  // Wide enough to hold WIDTH itself, so the counter never wraps mid-operation.
  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state;
  state_t           state_nxt;
  logic             busy_c;
  logic             done_c;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             last_bit;

  // Bits already produced, most recent at the MSB. Only WIDTH-1 of them ever
  // need storing: the final cell output completes the word on the last edge.
  logic [WIDTH-2:0] res;
  logic [WIDTH-1:0] res_nxt;

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic             fa_s;
  logic             fa_c;

  full_adder u_fa (
    .x (op_a[0]),
    .y (op_b[0]),
    .z (carry),
    .S (fa_s),
    .C (fa_c)
  );

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  assign res_nxt  = {fa_s, res};

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking (<=) assignments so
  // every flop samples values from before the edge, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy_c = 1'b1;
        if (last_bit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: operand shifters, carry flop, bit counter, result registers
  // ---------------------------------------------------------------------------
  // All datapath registers are small and are cleared so an abandoned operation
  // leaves no trace of its operands or partial result.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a   <= '0;
      op_b   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      res    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_a  <= bus.a;
            op_b  <= bus.b;
            carry <= bus.cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          op_a  <= op_a >> 1;
          op_b  <= op_b >> 1;
          carry <= fa_c;
          cnt   <= cnt + CNT_W'(1);
          res   <= res_nxt[WIDTH-1:1];
          if (last_bit) begin
            sum_q  <= res_nxt;
            cout_q <= fa_c;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy = busy_c;
  assign bus.done = done_c;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder: an 8-bit instance for the
// directed cases (reset, carries, ignored starts, reset abort) and a 3-bit
// instance swept exhaustively with back-to-back operations.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(3)) bus3 ();

  serial_adder #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  serial_adder #(.WIDTH(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One 8-bit addition. Called and returns on a falling edge with the DUT idle.
  // inject_at : RUN cycle in which a conflicting start (FF+FF+1) is pulsed, 0 = none
  // poke_done : pulse start during the DONE cycle and confirm it is ignored
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                     input logic [8:0] exp, input int inject_at, input bit poke_done,
                     input string tag);
    int         lat;
    int         busy_n;
    logic [7:0] sum0;
    logic       held;
    sum0 = bus8.sum;
    held = 1'b1;
    bus8.a = a; bus8.b = b; bus8.cin = c; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    lat = 1;
    busy_n = 0;
    while (!bus8.done && lat < 40) begin
      if (bus8.busy) busy_n++;
      if (bus8.sum !== sum0) held = 1'b0;
      if (lat == inject_at) begin
        bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.cin = 1'b1; bus8.start = 1'b1;
      end else begin
        bus8.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus8.start = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'd9);
    check({tag, " busy cycles"}, 32'(busy_n), 32'd8);
    check({tag, " sum held in RUN"}, 32'(held), 32'd1);
    check({tag, " busy with done"}, 32'(bus8.busy), 32'd0);
    check({tag, " result"}, 32'({bus8.cout, bus8.sum}), 32'(exp));
    if (poke_done) bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    check({tag, " done one cycle"}, 32'(bus8.done), 32'd0);
    if (poke_done) check({tag, " start in DONE ignored"}, 32'(bus8.busy), 32'd0);
  endtask

  // One 3-bit addition; returns in the IDLE cycle right after done so the
  // next call issues its start one cycle after the done pulse.
  task automatic op3(input logic [2:0] a, input logic [2:0] b, input logic c);
    int         lat;
    logic [3:0] exp;
    string      tag;
    exp = {1'b0, a} + {1'b0, b} + 4'(c);
    tag = $sformatf("w3 %0d+%0d+%0d", a, b, c);
    bus3.a = a; bus3.b = b; bus3.cin = c; bus3.start = 1'b1;
    @(negedge clk);
    bus3.start = 1'b0;
    lat = 1;
    while (!bus3.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd4);
    check({tag, " result"}, 32'({bus3.cout, bus3.sum}), 32'(exp));
    @(negedge clk);
  endtask

  initial begin
    logic saw_done;
    logic saw_busy;
    logic sum_moved;

    rst = 1'b1;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus3.start = 1'b0; bus3.a = '0; bus3.b = '0; bus3.cin = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("reset busy", 32'(bus8.busy), 32'd0);
    check("reset done", 32'(bus8.done), 32'd0);
    check("reset sum", 32'(bus8.sum), 32'd0);
    check("reset cout", 32'(bus8.cout), 32'd0);
    check("reset w3 busy", 32'(bus3.busy), 32'd0);
    check("reset w3 result", 32'({bus3.cout, bus3.sum}), 32'd0);

    @(negedge clk);
    op8(8'h00, 8'h00, 1'b0, 9'h000, 0, 1'b0, "zero");
    op8(8'hFF, 8'h01, 1'b0, 9'h100, 0, 1'b0, "ff+01");
    op8(8'hA5, 8'h5A, 1'b1, 9'h100, 0, 1'b1, "a5+5a+1");
    op8(8'h3C, 8'h42, 1'b0, 9'h07E, 3, 1'b0, "3c+42 restart");

    // Reset in RUN cycle 4 abandons the operation and clears the result.
    bus8.a = 8'h12; bus8.b = 8'h34; bus8.cin = 1'b0; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort busy before rst", 32'(bus8.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", 32'(bus8.busy), 32'd0);
    check("abort done", 32'(bus8.done), 32'd0);
    check("abort result", 32'({bus8.cout, bus8.sum}), 32'd0);
    saw_done = 1'b0;
    saw_busy = 1'b0;
    sum_moved = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus8.done) saw_done = 1'b1;
      if (bus8.busy) saw_busy = 1'b1;
      if ({bus8.cout, bus8.sum} !== 9'h000) sum_moved = 1'b1;
    end
    check("abort no done", 32'(saw_done), 32'd0);
    check("abort stays idle", 32'(saw_busy), 32'd0);
    check("abort result held", 32'(sum_moved), 32'd0);

    // Reset wins over a simultaneous start.
    bus8.a = 8'h12; bus8.b = 8'h34; bus8.start = 1'b1; rst = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0; rst = 1'b0;
    check("rst vs start busy", 32'(bus8.busy), 32'd0);
    saw_busy = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus8.busy) saw_busy = 1'b1;
      if (bus8.done) saw_done = 1'b1;
    end
    check("rst vs start idle", 32'(saw_busy), 32'd0);
    check("rst vs start no done", 32'(saw_done), 32'd0);

    // 3-bit exhaustive sweep, back-to-back.
    for (int i = 0; i < 128; i++) begin
      logic [6:0] v;
      v = 7'(i);
      op3(v[2:0], v[5:3], v[6]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand and sum width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  synchronous reset, active-high, sampled on the rising edge of clk.
REQ-004 Port: start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  first operand; captured on an accepted start.
REQ-006 Port: b  input  WIDTH  second operand; captured on an accepted start.
REQ-007 Port: cin  input  1  carry-in; captured on an accepted start.
REQ-008 Port: busy  output  1  high while an addition is in progress (RUN state).
REQ-009 Port: done  output  1  one-cycle pulse marking that sum and cout carry the new result.
REQ-010 Port: sum  output  WIDTH  registered result of a + b + cin, modulo 2^WIDTH.
REQ-011 Port: cout  output  1  registered carry-out of the completed addition.

Function
REQ-012 The block SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-013 In IDLE with start=1, the block SHALL load a and b into operand shift registers, load cin into the carry flop, clear the bit counter, and go to RUN.
REQ-014 In IDLE with start=0, the block SHALL hold all registers unchanged.
REQ-015 In RUN, each cycle SHALL add operand bit 0 of each register and the carry flop through one full-adder cell.
REQ-016 In RUN, each cycle SHALL also right-shift both operand registers, shift the sum bit into the MSB of an internal result shift register, load the carry flop with the cell carry, and increment the counter.
REQ-017 Bits SHALL be processed LSB first; the counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap within one operation.
REQ-018 On the RUN cycle processing bit WIDTH-1, the FSM SHALL go to DONE.
REQ-019 On that same edge, sum SHALL be loaded with the full result and cout with the final cell carry.
REQ-020 In DONE, done SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE on the next edge.
REQ-021 start asserted during the DONE cycle SHALL be ignored; start is accepted only in IDLE.
REQ-022 Latency: start accepted at edge t SHALL give done=1 in the cycle after edge t+WIDTH. Minimum start-to-start spacing is WIDTH+2 cycles.
REQ-023 start while busy=1 SHALL be ignored; operands and carry in flight SHALL be unaffected.
REQ-024 sum and cout SHALL hold the last completed result until the next completion edge; they SHALL NOT change during RUN.
REQ-025 busy SHALL be 1 only in RUN; done SHALL be 1 only in DONE; busy and done SHALL never be high together.
REQ-026 Arithmetic SHALL be unsigned: {cout,sum} = a + b + cin for all inputs, including all-ones operands with cin=1.

Reset
REQ-027 rst=1 at any edge SHALL force IDLE, busy=0, done=0, sum=0, cout=0, carry flop=0 and counter=0, and clear the operand and result shift registers.
REQ-028 rst SHALL take priority over start in the same cycle.
REQ-029 An operation interrupted by rst SHALL be abandoned, with no done pulse and no update of sum or cout.

Structure
REQ-030 The FSM state encoding (IDLE, RUN, DONE) SHALL be defined as a typedef in the shared package serial_arith_pkg, together with the WIDTH default constant.
REQ-031 The per-bit add SHALL instantiate the existing full_adder cell (x, y, z -> S, C) as the single sub-module; no other arithmetic operator SHALL be used for the sum path.

Verification
REQ-032 WIDTH=8, a=0x00, b=0x00, cin=0, start pulse -> busy for 8 cycles, done pulse at cycle 9, sum=0x00, cout=0.
REQ-033 WIDTH=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1.
REQ-034 WIDTH=8, a=0x3C, b=0x42, cin=0, then start re-pulsed with a=0xFF, b=0xFF at RUN cycle 3 -> second start ignored; sum=0x7E, cout=0.
REQ-035 WIDTH=8, a=0x12, b=0x34, rst asserted at RUN cycle 4 -> IDLE next cycle, no done pulse, sum=0x00, cout=0.
REQ-036 Same setup with start and rst asserted in the same cycle -> stays in IDLE, busy=0.
REQ-037 WIDTH=3, exhaustive sweep of a, b and cin (128 cases), back-to-back starts issued one cycle after each done -> {cout,sum} matches a+b+cin in every case, and latency is 4 cycles for every case.
